// File: rtl/viterbi_seq_ctrl_pkg.sv
// Shared types and constants for the Viterbi symbol sequencer.
package viterbi_seq_ctrl_pkg;

  localparam int NUM_STATES    = 4;
  localparam int NUM_BRANCHES  = 8;
  localparam int FRAME_LEN_DEF = 16;
  localparam int ST_W          = $clog2(NUM_STATES);
  localparam int BR_W          = $clog2(NUM_BRANCHES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVAL     = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_TB_START = 3'd3,
    ST_TB_WAIT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/viterbi_seq_ctrl_if.sv
// Bundle between the sequencer and its requester / datapath units.
// Handshake: the requester holds seq_rdy high with rx stable; a one-cycle
// data_ack marks the capture, after which rx may change or seq_rdy may drop.
interface viterbi_seq_ctrl_if #(
  parameter int CNT_W = 6
);
  logic [1:0]       rx;
  logic             seq_rdy;
  logic             tb_done;
  logic             data_ack;
  logic [1:0]       rx_hold;
  logic [1:0]       cur_state;
  logic             input_bit;
  logic             bm_valid;
  logic             pm_init;
  logic             pm_commit;
  logic             tb_start;
  logic [CNT_W-1:0] sym_cnt;
  logic             busy;

  modport master (
    output rx, seq_rdy, tb_done,
    input  data_ack, rx_hold, cur_state, input_bit, bm_valid,
           pm_init, pm_commit, tb_start, sym_cnt, busy
  );

  modport slave (
    input  rx, seq_rdy, tb_done,
    output data_ack, rx_hold, cur_state, input_bit, bm_valid,
           pm_init, pm_commit, tb_start, sym_cnt, busy
  );
endinterface

// File: rtl/viterbi_seq_ctrl_sym_counter.sv
// Committed-symbol counter for one frame, with terminal flag on the last symbol.
module viterbi_sym_counter
  import viterbi_seq_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == CNT_W'(FRAME_LEN - 1));
endmodule

// File: rtl/viterbi_seq_ctrl.sv
// Sequences one received symbol through the 8 trellis branches, commits the
// path metrics and hands each full frame to the traceback unit.
module viterbi_seq_ctrl
  import viterbi_seq_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  viterbi_seq_ctrl_if.slave        bus,
  output seq_state_e               fsm_state_o
);
  seq_state_e       state_q;
  logic [BR_W-1:0]  br_q;
  logic [1:0]       rx_hold_q;
  logic             data_ack_q;
  logic             bm_valid_q;
  logic             pm_init_q;
  logic             pm_commit_q;
  logic             tb_start_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_term;
  logic             cnt_inc;
  logic             cnt_clr;

  // The count advances on the edge that closes the commit cycle, so the
  // terminal flag seen during COMMIT still refers to the symbol being committed.
  assign cnt_inc = (state_q == ST_COMMIT);
  assign cnt_clr = (state_q == ST_TB_WAIT) && bus.tb_done;

  viterbi_sym_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_sym_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (cnt_inc),
    .clr_i  (cnt_clr),
    .cnt_o  (cnt),
    .term_o (cnt_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      br_q        <= '0;
      rx_hold_q   <= '0;
      data_ack_q  <= 1'b0;
      bm_valid_q  <= 1'b0;
      pm_init_q   <= 1'b0;
      pm_commit_q <= 1'b0;
      tb_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      data_ack_q  <= 1'b0;
      pm_commit_q <= 1'b0;
      tb_start_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.seq_rdy) begin
            rx_hold_q  <= bus.rx;
            data_ack_q <= 1'b1;
            br_q       <= '0;
            bm_valid_q <= 1'b1;
            pm_init_q  <= (cnt == '0);
            busy_q     <= 1'b1;
            state_q    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (br_q == BR_W'(NUM_BRANCHES - 1)) begin
            br_q        <= '0;
            bm_valid_q  <= 1'b0;
            pm_init_q   <= 1'b0;
            pm_commit_q <= 1'b1;
            state_q     <= ST_COMMIT;
          end else begin
            br_q <= br_q + BR_W'(1);
          end
        end
        ST_COMMIT: begin
          if (cnt_term) begin
            tb_start_q <= 1'b1;
            state_q    <= ST_TB_START;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_TB_START: state_q <= ST_TB_WAIT;
        ST_TB_WAIT: begin
          if (bus.tb_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_ack  = data_ack_q;
  assign bus.rx_hold   = rx_hold_q;
  assign bus.cur_state = br_q[BR_W-1:1];
  assign bus.input_bit = br_q[0];
  assign bus.bm_valid  = bm_valid_q;
  assign bus.pm_init   = pm_init_q;
  assign bus.pm_commit = pm_commit_q;
  assign bus.tb_start  = tb_start_q;
  assign bus.sym_cnt   = cnt;
  assign bus.busy      = busy_q;
  assign fsm_state_o   = state_q;
endmodule
